// File: rtl/mdu_issue_ctrl.sv
// ============================================================================
// Module      : mdu_issue_ctrl
// Description : Issues one HI/LO-class op per instruction to the multiply/divide
//               unit, tracks its busy window and stalls D until it is free.
//               Optional: MDU_DIV0_SKIP_EN drops divides by zero at accept.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_issue_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [3:0]  e_mdu_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_uses_mdu,
    input  logic        mdu_busy,
    output logic [3:0]  mdu_op,
    output logic [31:0] mdu_r1,
    output logic [31:0] mdu_r2,
    output logic        stall_d,
    output logic [1:0]  state,
    output logic        err_overlap
);

    localparam int c_CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t               r_state;
    logic [3:0]           r_mdu_op;
    logic [31:0]          r_mdu_r1;
    logic [31:0]          r_mdu_r2;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_err;

    logic                 w_issued;
    logic                 w_skip;
    logic                 w_accept;
    logic [c_CNT_W-1:0]   w_cnt_dec;

    // mfhi/mflo read HI/LO directly and are never sent to the MDU
    always_comb begin
        w_issued = 1'b0;
        case (e_mdu_op)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8: w_issued = 1'b1;
            default:                            w_issued = 1'b0;
        endcase
    end

`ifdef MDU_DIV0_SKIP_EN
    assign w_skip = ((e_mdu_op == 4'd3) || (e_mdu_op == 4'd4)) && (e_rt == 32'd0);
`else
    assign w_skip = 1'b0;
`endif

    assign w_accept  = (r_state == S_IDLE) && e_valid && w_issued && !w_skip;
    assign w_cnt_dec = (r_cnt == '0) ? '0 : r_cnt - 1'b1;

    // The count loaded at issue equals the number of WAIT cycles, so the
    // exit decision looks at the value the counter reaches on this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mdu_op <= 4'd0;
            r_mdu_r1 <= 32'd0;
            r_mdu_r2 <= 32'd0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            if ((e_valid && w_issued && (r_state != S_IDLE)) ||
                (mdu_busy && (r_state == S_IDLE))) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mdu_op <= e_mdu_op;
                        r_mdu_r1 <= e_rs;
                        r_mdu_r2 <= e_rt;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_mdu_op <= 4'd0;
                    case (r_mdu_op)
                        4'd1, 4'd2: begin
                            r_cnt   <= c_CNT_W'(MUL_CYCLES);
                            r_state <= S_WAIT;
                        end
                        4'd3, 4'd4: begin
                            r_cnt   <= c_CNT_W'(DIV_CYCLES);
                            r_state <= S_WAIT;
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_dec;
                    if ((w_cnt_dec == '0) && !mdu_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_mdu_op <= 4'd0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_d     = d_uses_mdu && ((r_state != S_IDLE) || w_accept);
    assign mdu_op      = r_mdu_op;
    assign mdu_r1      = r_mdu_r1;
    assign mdu_r2      = r_mdu_r2;
    assign state       = r_state;
    assign err_overlap = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mdu_issue_ctrl.sv
// ============================================================================
// Module      : tb_mdu_issue_ctrl
// Description : Directed self-checking bench for mdu_issue_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_valid;
    logic [3:0]  e_mdu_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_uses_mdu;
    logic        mdu_busy;
    logic [3:0]  mdu_op;
    logic [31:0] mdu_r1;
    logic [31:0] mdu_r2;
    logic        stall_d;
    logic [1:0]  state;
    logic        err_overlap;

    int n_checks = 0;
    int n_errors = 0;

    mdu_issue_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .e_valid     (e_valid),
        .e_mdu_op    (e_mdu_op),
        .e_rs        (e_rs),
        .e_rt        (e_rt),
        .d_uses_mdu  (d_uses_mdu),
        .mdu_busy    (mdu_busy),
        .mdu_op      (mdu_op),
        .mdu_r1      (mdu_r1),
        .mdu_r2      (mdu_r2),
        .stall_d     (stall_d),
        .state       (state),
        .err_overlap (err_overlap)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (state != 2'd0 && n < 40) begin
            next_cycle();
            #2;
            n++;
        end
        check_eq("idle_timeout", {30'd0, state}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; e_valid = 1'b0; e_mdu_op = 4'd0; e_rs = 32'd0; e_rt = 32'd0;
        d_uses_mdu = 1'b1; mdu_busy = 1'b0;
        next_cycle(); next_cycle(); #2;
        check_eq("rst_state", {30'd0, state}, 32'd0);
        check_eq("rst_op", {28'd0, mdu_op}, 32'd0);
        check_eq("rst_r1", mdu_r1, 32'd0);
        check_eq("rst_r2", mdu_r2, 32'd0);
        check_eq("rst_err", {31'd0, err_overlap}, 32'd0);
        check_eq("rst_stall", {31'd0, stall_d}, 32'd0);
        reset = 1'b0;

        // mult 7*6 with mfhi held in D
        next_cycle();
        e_valid = 1'b1; e_mdu_op = 4'd1; e_rs = 32'd7; e_rt = 32'd6; d_uses_mdu = 1'b1; #2;
        check_eq("mul_c1_stall", {31'd0, stall_d}, 32'd1);
        check_eq("mul_c1_state", {30'd0, state}, 32'd0);
        next_cycle(); e_valid = 1'b0; e_mdu_op = 4'd0; #2;
        check_eq("mul_c2_op", {28'd0, mdu_op}, 32'd1);
        check_eq("mul_c2_state", {30'd0, state}, 32'd1);
        check_eq("mul_c2_r1", mdu_r1, 32'd7);
        check_eq("mul_c2_r2", mdu_r2, 32'd6);
        check_eq("mul_c2_stall", {31'd0, stall_d}, 32'd1);
        for (int c = 3; c <= 7; c++) begin
            next_cycle(); #2;
            check_eq($sformatf("mul_c%0d_state", c), {30'd0, state}, 32'd2);
            check_eq($sformatf("mul_c%0d_op", c), {28'd0, mdu_op}, 32'd0);
            check_eq($sformatf("mul_c%0d_stall", c), {31'd0, stall_d}, 32'd1);
        end
        next_cycle(); #2;
        check_eq("mul_c8_state", {30'd0, state}, 32'd0);
        check_eq("mul_c8_stall", {31'd0, stall_d}, 32'd0);

        // divu 100/7 with a mult held in D
        next_cycle();
        e_valid = 1'b1; e_mdu_op = 4'd4; e_rs = 32'd100; e_rt = 32'd7; d_uses_mdu = 1'b1; #2;
        check_eq("divu_acc_stall", {31'd0, stall_d}, 32'd1);
        next_cycle(); e_valid = 1'b0; e_mdu_op = 4'd0; #2;
        check_eq("divu_op", {28'd0, mdu_op}, 32'd4);
        check_eq("divu_r1", mdu_r1, 32'd100);
        for (int c = 1; c <= 10; c++) begin
            next_cycle(); #2;
            check_eq($sformatf("divu_w%0d_state", c), {30'd0, state}, 32'd2);
            check_eq($sformatf("divu_w%0d_stall", c), {31'd0, stall_d}, 32'd1);
        end
        next_cycle(); #2;
        check_eq("divu_done_state", {30'd0, state}, 32'd0);
        check_eq("divu_done_stall", {31'd0, stall_d}, 32'd0);
        next_cycle();
        e_valid = 1'b1; e_mdu_op = 4'd1; e_rs = 32'd3; e_rt = 32'd5; d_uses_mdu = 1'b0;
        next_cycle(); e_valid = 1'b0; e_mdu_op = 4'd0; #2;
        check_eq("divu_mul_op", {28'd0, mdu_op}, 32'd1);
        check_eq("divu_mul_r2", mdu_r2, 32'd5);
        check_eq("divu_err", {31'd0, err_overlap}, 32'd0);
        wait_idle();

        // mthi then mflo in D: two stall cycles
        next_cycle();
        e_valid = 1'b1; e_mdu_op = 4'd7; e_rs = 32'hDEADBEEF; e_rt = 32'd0; d_uses_mdu = 1'b1; #2;
        check_eq("mthi_s1_stall", {31'd0, stall_d}, 32'd1);
        next_cycle(); e_valid = 1'b0; e_mdu_op = 4'd0; #2;
        check_eq("mthi_op", {28'd0, mdu_op}, 32'd7);
        check_eq("mthi_r1", mdu_r1, 32'hDEADBEEF);
        check_eq("mthi_s2_stall", {31'd0, stall_d}, 32'd1);
        next_cycle(); #2;
        check_eq("mthi_idle", {30'd0, state}, 32'd0);
        check_eq("mthi_op_clr", {28'd0, mdu_op}, 32'd0);
        check_eq("mthi_s3_stall", {31'd0, stall_d}, 32'd0);
        d_uses_mdu = 1'b0;

        // busy stretched two cycles past the counter
        next_cycle(); e_valid = 1'b1; e_mdu_op = 4'd2; e_rs = 32'd2; e_rt = 32'd2;
        next_cycle(); e_valid = 1'b0; e_mdu_op = 4'd0;
        for (int c = 1; c <= 6; c++) begin
            next_cycle(); mdu_busy = 1'b1; #2;
            check_eq($sformatf("busy_w%0d_state", c), {30'd0, state}, 32'd2);
        end
        next_cycle(); mdu_busy = 1'b0; #2;
        check_eq("busy_w7_state", {30'd0, state}, 32'd2);
        next_cycle(); #2;
        check_eq("busy_exit_state", {30'd0, state}, 32'd0);
        check_eq("busy_err_clean", {31'd0, err_overlap}, 32'd0);
        mdu_busy = 1'b1;
        next_cycle(); mdu_busy = 1'b0; #2;
        check_eq("busy_idle_err", {31'd0, err_overlap}, 32'd1);
        next_cycle(); #2;
        check_eq("busy_err_sticky", {31'd0, err_overlap}, 32'd1);

        // reset in the fourth WAIT cycle of a div
        next_cycle(); reset = 1'b1;
        next_cycle(); reset = 1'b0;
        e_valid = 1'b1; e_mdu_op = 4'd3; e_rs = 32'd9; e_rt = 32'd3;
        next_cycle(); e_valid = 1'b0; e_mdu_op = 4'd0;
        for (int c = 1; c <= 4; c++) next_cycle();
        reset = 1'b1; d_uses_mdu = 1'b1;
        next_cycle(); reset = 1'b0; #2;
        check_eq("rstw_state", {30'd0, state}, 32'd0);
        check_eq("rstw_op", {28'd0, mdu_op}, 32'd0);
        check_eq("rstw_stall", {31'd0, stall_d}, 32'd0);
        check_eq("rstw_err", {31'd0, err_overlap}, 32'd0);
        d_uses_mdu = 1'b0;
        e_valid = 1'b1; e_mdu_op = 4'd1; e_rs = 32'd11; e_rt = 32'd12;
        next_cycle(); e_valid = 1'b0; e_mdu_op = 4'd0; #2;
        check_eq("rstw_mul_op", {28'd0, mdu_op}, 32'd1);
        check_eq("rstw_mul_r1", mdu_r1, 32'd11);
        wait_idle();

        // op presented while busy: flagged and dropped
        next_cycle(); e_valid = 1'b1; e_mdu_op = 4'd1; e_rs = 32'd7; e_rt = 32'd1;
        next_cycle(); e_mdu_op = 4'd2; e_rs = 32'd55; e_rt = 32'd66; #2;
        check_eq("ovl_issue_state", {30'd0, state}, 32'd1);
        next_cycle(); e_valid = 1'b0; e_mdu_op = 4'd0; #2;
        check_eq("ovl_err", {31'd0, err_overlap}, 32'd1);
        check_eq("ovl_r1_kept", mdu_r1, 32'd7);
        check_eq("ovl_state", {30'd0, state}, 32'd2);
        wait_idle();
        next_cycle(); reset = 1'b1;
        next_cycle(); reset = 1'b0;

        // never-issued codes
        e_valid = 1'b1; e_mdu_op = 4'd5; d_uses_mdu = 1'b1; #2;
        check_eq("mfhi_no_stall", {31'd0, stall_d}, 32'd0);
        next_cycle(); e_mdu_op = 4'd9; #2;
        check_eq("mfhi_state", {30'd0, state}, 32'd0);
        next_cycle(); e_valid = 1'b0; e_mdu_op = 4'd0; #2;
        check_eq("code9_state", {30'd0, state}, 32'd0);
        check_eq("code9_op", {28'd0, mdu_op}, 32'd0);

        // divide by zero
        next_cycle();
        e_valid = 1'b1; e_mdu_op = 4'd3; e_rs = 32'd5; e_rt = 32'd0; d_uses_mdu = 1'b1; #2;
`ifdef MDU_DIV0_SKIP_EN
        check_eq("div0_stall", {31'd0, stall_d}, 32'd0);
        next_cycle(); e_valid = 1'b0; e_mdu_op = 4'd0; #2;
        check_eq("div0_op", {28'd0, mdu_op}, 32'd0);
        check_eq("div0_state", {30'd0, state}, 32'd0);
`else
        check_eq("div0_stall", {31'd0, stall_d}, 32'd1);
        next_cycle(); e_valid = 1'b0; e_mdu_op = 4'd0; #2;
        check_eq("div0_op", {28'd0, mdu_op}, 32'd3);
        check_eq("div0_state", {30'd0, state}, 32'd1);
        for (int c = 1; c <= 10; c++) begin
            next_cycle(); #2;
            check_eq($sformatf("div0_w%0d_state", c), {30'd0, state}, 32'd2);
        end
        next_cycle(); #2;
        check_eq("div0_done_state", {30'd0, state}, 32'd0);
`endif
        check_eq("div0_err", {31'd0, err_overlap}, 32'd0);
        d_uses_mdu = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
